led_pio_ctrl: RTL

Parametrised Avalon-MM output PIO driving board LEDs; the successor to the fixed 8-bit write-only LED port in the Qsys system. It adds width/reset-value parameters, atomic SET/CLEAR/TOGGLE write aliases and a per-bit hardware blink engine with a programmable half-period. It sits on the Qsys data master as a zero-wait-state slave, with `out_port` exported to the top-level LED pins.

---
 rtl/led_pio_pkg.sv | 14 +
 rtl/led_pio_blink_timer.sv | 42 ++++
 rtl/led_pio_ctrl.sv | 100 ++++++++++
 3 files changed

// File: rtl/led_pio_pkg.sv
// Shared register map and PERIOD width for the LED PIO block and its blink timer.
package led_pio_pkg;

    localparam int LED_PERIOD_W = 32;

    localparam logic [2:0] LED_ADDR_DATA   = 3'd0;
    localparam logic [2:0] LED_ADDR_MASK   = 3'd1;
    localparam logic [2:0] LED_ADDR_PERIOD = 3'd2;
    localparam logic [2:0] LED_ADDR_STATUS = 3'd3;
    localparam logic [2:0] LED_ADDR_SET    = 3'd4;
    localparam logic [2:0] LED_ADDR_CLEAR  = 3'd5;
    localparam logic [2:0] LED_ADDR_TOGGLE = 3'd6;

endpackage

// File: rtl/led_pio_blink_timer.sv
// Blink half-period timer: phase toggles every PERIOD cycles; PERIOD==0 halts it cleared.
// Latency: a PERIOD write clears cnt/phase on its own edge; first toggle PERIOD edges later.
// Backpressure: none, free-running.
module led_pio_blink_timer
    import led_pio_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic [LED_PERIOD_W-1:0] period,
    input  logic                    period_wr,
    output logic                    phase
);

    logic [LED_PERIOD_W-1:0] cnt_q, cnt_d;
    logic                    phase_q, phase_d;

    always_comb begin
        cnt_d   = cnt_q + 1'b1;
        phase_d = phase_q;
        // A PERIOD write restarts the half-period even if a wrap was due this cycle.
        if (period_wr || period == '0) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (cnt_q == period - 1'b1) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/led_pio_ctrl.sv
// Avalon-MM LED output PIO with SET/CLEAR/TOGGLE aliases; blink engine under LED_PIO_BLINK_EN.
// Latency: zero-wait-state reads (combinational), writes visible on out_port from the write edge.
// Backpressure: none, slave always ready; one access per cycle.
module led_pio_ctrl
    import led_pio_pkg::*;
#(
    parameter int                WIDTH          = 8,
    parameter logic [WIDTH-1:0]  RESET_VALUE    = '0,
    parameter logic [31:0]       DEFAULT_PERIOD = 32'd25000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    logic             wr;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] data_q, data_d;
    logic             unused_wd;

    assign wr        = chipselect & ~write_n;
    assign wd        = writedata[WIDTH-1:0];
    assign unused_wd = ^writedata;

    always_comb begin
        data_d = data_q;
        if (wr) begin
            case (address)
                LED_ADDR_DATA:   data_d = wd;
                LED_ADDR_SET:    data_d = data_q | wd;
                LED_ADDR_CLEAR:  data_d = data_q & ~wd;
                LED_ADDR_TOGGLE: data_d = data_q ^ wd;
                default:         data_d = data_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) data_q <= RESET_VALUE;
        else       data_q <= data_d;
    end

`ifdef LED_PIO_BLINK_EN
    logic [WIDTH-1:0]        mask_q, mask_d;
    logic [LED_PERIOD_W-1:0] period_q, period_d;
    logic                    period_wr;
    logic                    phase;

    assign period_wr = wr && (address == LED_ADDR_PERIOD);

    always_comb begin
        mask_d   = mask_q;
        period_d = period_q;
        if (wr && address == LED_ADDR_MASK) mask_d = wd;
        if (period_wr)                      period_d = writedata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_q   <= '0;
            period_q <= DEFAULT_PERIOD;
        end else begin
            mask_q   <= mask_d;
            period_q <= period_d;
        end
    end

    // Timer sees the registered period, so the value written takes effect right after its clearing edge.
    led_pio_blink_timer u_timer (
        .clk       (clk),
        .reset     (reset),
        .period    (period_q),
        .period_wr (period_wr),
        .phase     (phase)
    );

    assign out_port = data_q & ~(mask_q & {WIDTH{phase}});
`else
    assign out_port = data_q;
`endif

    always_comb begin
        readdata = '0;
        case (address)
            LED_ADDR_DATA:   readdata[WIDTH-1:0] = data_q;
`ifdef LED_PIO_BLINK_EN
            LED_ADDR_MASK:   readdata[WIDTH-1:0] = mask_q;
            LED_ADDR_PERIOD: readdata            = period_q;
            LED_ADDR_STATUS: readdata[0]         = phase;
`endif
            default:         readdata = '0;
        endcase
    end

endmodule
